// File: rtl/microcode_sequencer.sv
// Writable-microcode control sequencer: steps T-states and emits the datapath control word,
// with variable-length instructions, flag-conditional steps, HALT and run/stall.
module microcode_sequencer #(
    parameter int              OPCODE_W  = 4,
    parameter int              CTRL_W    = 15,
    parameter int              NUM_T     = 6,
    parameter int              FETCH_T   = 3,
    parameter logic [CTRL_W-1:0] IDLE_WORD = 15'h0FE3,
    localparam int             DEPTH     = FETCH_T + (2**OPCODE_W) * (NUM_T - FETCH_T),
    localparam int             AW        = $clog2(DEPTH),
    localparam int             WORD_W    = CTRL_W + 4,
    localparam int             TW        = $clog2(NUM_T)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                cf,
    input  logic                zf,
    input  logic                run,
    input  logic                uc_we,
    input  logic [AW-1:0]       uc_addr,
    input  logic [WORD_W-1:0]   uc_wdata,
    output logic [CTRL_W-1:0]   ctrl_out,
    output logic [TW-1:0]       t_state,
    output logic                halted,
    output logic                instr_done
);

    typedef enum logic {ST_RUN, ST_HALT} state_t;

    localparam logic [WORD_W-1:0] IDLE_ROW = {4'b0000, IDLE_WORD};

    state_t            state;
    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]     row;
    logic [WORD_W-1:0] word;
    logic              end_bit;
    logic              hlt_bit;
    logic [1:0]        cond;
    logic              pass;
    logic              last;

    // Fetch steps share rows 0..FETCH_T-1; execute steps index a per-opcode block.
    always_comb begin
        if (t_state < TW'(FETCH_T))
            row = AW'(t_state);
        else
            row = AW'(FETCH_T) + AW'(opcode) * AW'(NUM_T - FETCH_T)
                + AW'(t_state) - AW'(FETCH_T);
    end

    assign word    = mem[row];
    assign end_bit = word[CTRL_W];
    assign hlt_bit = word[CTRL_W+1];
    assign cond    = word[CTRL_W+3:CTRL_W+2];
    assign halted  = (state == ST_HALT);

    always_comb begin
        pass = 1'b1;
        case (cond)
            2'b00: pass = 1'b1;
            2'b01: pass = cf;
            2'b10: pass = zf;
            2'b11: pass = ~zf;
        endcase
    end

    // A failed condition both idles the step and terminates the instruction.
    assign last       = ~pass | end_bit | (t_state == TW'(NUM_T - 1));
    assign instr_done = run & ~halted & ~(pass & hlt_bit) & last;

    always_comb begin
        ctrl_out = IDLE_WORD;
        if (!halted && run && pass)
            ctrl_out = word[CTRL_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_RUN;
            t_state <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= IDLE_ROW;
        end else begin
            if (uc_we && (int'(uc_addr) < DEPTH))
                mem[uc_addr] <= uc_wdata;
            // HLT wins over END; once halted only reset restarts the sequencer.
            if (state == ST_RUN && run) begin
                if (pass && hlt_bit)
                    state <= ST_HALT;
                else if (last)
                    t_state <= '0;
                else
                    t_state <= t_state + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed self-checking bench for microcode_sequencer at default parameters.
module tb_microcode_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  opcode;
    logic        cf;
    logic        zf;
    logic        run;
    logic        uc_we;
    logic [5:0]  uc_addr;
    logic [18:0] uc_wdata;
    logic [14:0] ctrl_out;
    logic [2:0]  t_state;
    logic        halted;
    logic        instr_done;

    int total = 0;
    int bad   = 0;

    microcode_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .cf         (cf),
        .zf         (zf),
        .run        (run),
        .uc_we      (uc_we),
        .uc_addr    (uc_addr),
        .uc_wdata   (uc_wdata),
        .ctrl_out   (ctrl_out),
        .t_state    (t_state),
        .halted     (halted),
        .instr_done (instr_done)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle well after it before driving or sampling.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic checkStep(input string tag, input int t, input logic [14:0] ctrl, input logic done);
        #1;
        checkOutput({tag, ".t"}, 32'(t_state), 32'(t));
        checkOutput({tag, ".ctrl"}, 32'(ctrl_out), 32'(ctrl));
        checkOutput({tag, ".done"}, 32'(instr_done), 32'(done));
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] op, input logic c, input logic z);
        run    = r;
        opcode = op;
        cf     = c;
        zf     = z;
    endtask

    function automatic logic [18:0] mkWord(input logic [1:0] cnd, input logic h, input logic e,
                                           input logic [14:0] c);
        return {cnd, h, e, c};
    endfunction

    task automatic writeRow(input logic [5:0] addr, input logic [18:0] w);
        uc_we    = 1'b1;
        uc_addr  = addr;
        uc_wdata = w;
        step();
        uc_we    = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        uc_we = 1'b0;
        uc_addr = '0;
        uc_wdata = '0;
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
        step();
        rst = 1'b0;

        // Defaults: idle word everywhere, full six-step instructions
        applyStimulus(1'b1, 4'd0, 1'b0, 1'b0);
        #1;
        checkOutput("reset.halted", 32'(halted), 32'd0);
        for (int i = 0; i < 12; i++) begin
            checkStep("default", i % 6, 15'h0FE3, (i % 6) == 5);
            step();
        end

        // Fetch rows plus a four-step opcode 1 with early END
        run = 1'b0;
        writeRow(6'd0, mkWord(2'b00, 1'b0, 1'b0, 15'h2FE3));
        writeRow(6'd1, mkWord(2'b00, 1'b0, 1'b0, 15'h7DE3));
        writeRow(6'd2, mkWord(2'b00, 1'b0, 1'b0, 15'h0F63));
        writeRow(6'd6, mkWord(2'b00, 1'b0, 1'b1, 15'h0EE3));
        applyStimulus(1'b1, 4'd1, 1'b0, 1'b0);
        checkStep("op1.t0", 0, 15'h2FE3, 1'b0); step();
        checkStep("op1.t1", 1, 15'h7DE3, 1'b0); step();
        checkStep("op1.t2", 2, 15'h0F63, 1'b0); step();
        checkStep("op1.t3", 3, 15'h0EE3, 1'b1); step();
        checkStep("op1.wrap", 0, 15'h2FE3, 1'b0);

        // COND=01 on carry
        run = 1'b0;
        writeRow(6'd24, mkWord(2'b01, 1'b0, 1'b0, 15'h1FE3));
        applyStimulus(1'b1, 4'd7, 1'b1, 1'b0);
        step(); step(); step();
        checkStep("cf1.t3", 3, 15'h1FE3, 1'b0); step();
        checkStep("cf1.t4", 4, 15'h0FE3, 1'b0); step();
        checkStep("cf1.t5", 5, 15'h0FE3, 1'b1); step();
        cf = 1'b0;
        step(); step(); step();
        checkStep("cf0.t3", 3, 15'h0FE3, 1'b1); step();
        checkStep("cf0.wrap", 0, 15'h2FE3, 1'b0);

        // COND=11 on not-zero
        run = 1'b0;
        writeRow(6'd24, mkWord(2'b11, 1'b0, 1'b0, 15'h1FE3));
        applyStimulus(1'b1, 4'd7, 1'b0, 1'b0);
        step(); step(); step();
        checkStep("nz.t3", 3, 15'h1FE3, 1'b0); step();
        checkStep("nz.t4", 4, 15'h0FE3, 1'b0); step(); step();
        zf = 1'b1;
        step(); step(); step();
        checkStep("z.t3", 3, 15'h0FE3, 1'b1); step();
        checkStep("z.wrap", 0, 15'h2FE3, 1'b0);

        // HLT at opcode 15 step 3, then reset (with a competing write) clears everything
        run = 1'b0;
        writeRow(6'd48, mkWord(2'b00, 1'b1, 1'b0, 15'h3333));
        applyStimulus(1'b1, 4'd15, 1'b0, 1'b0);
        step(); step(); step();
        checkStep("hlt.t3", 3, 15'h3333, 1'b0);
        step();
        for (int i = 0; i < 20; i++) begin
            checkStep("halted", 3, 15'h0FE3, 1'b0);
            checkOutput("halted.flag", 32'(halted), 32'd1);
            step();
        end
        rst = 1'b1;
        writeRow(6'd0, mkWord(2'b00, 1'b0, 1'b0, 15'h7777));
        rst = 1'b0;
        applyStimulus(1'b1, 4'd1, 1'b0, 1'b0);
        checkStep("rst.t0", 0, 15'h0FE3, 1'b0);
        checkOutput("rst.halted", 32'(halted), 32'd0);
        step(); step(); step();
        checkStep("rst.row6", 3, 15'h0FE3, 1'b0); step();
        checkStep("rst.t4", 4, 15'h0FE3, 1'b0); step(); step();

        // Stall at t=2
        run = 1'b0;
        writeRow(6'd2, mkWord(2'b00, 1'b0, 1'b0, 15'h0F63));
        applyStimulus(1'b1, 4'd0, 1'b0, 1'b0);
        step(); step();
        checkStep("pre.stall", 2, 15'h0F63, 1'b0);
        run = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkStep("stall", 2, 15'h0FE3, 1'b0);
            step();
        end
        run = 1'b1;
        checkStep("resume", 2, 15'h0F63, 1'b0); step();
        checkStep("resume.t3", 3, 15'h0FE3, 1'b0); step(); step(); step();

        // Out-of-range write is ignored
        run = 1'b0;
        writeRow(6'd60, mkWord(2'b00, 1'b0, 1'b1, 15'h5555));
        applyStimulus(1'b1, 4'd3, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            checkStep("oor", i, (i == 2) ? 15'h0F63 : 15'h0FE3, i == 5);
            step();
        end

        // Overwrite the live row: old word this cycle, new word next pass
        run = 1'b0;
        writeRow(6'd6, mkWord(2'b00, 1'b0, 1'b1, 15'h0EE3));
        applyStimulus(1'b1, 4'd1, 1'b0, 1'b0);
        step(); step(); step();
        uc_we    = 1'b1;
        uc_addr  = 6'd6;
        uc_wdata = mkWord(2'b00, 1'b0, 1'b1, 15'h1AE3);
        checkStep("ow.old", 3, 15'h0EE3, 1'b1);
        step();
        uc_we = 1'b0;
        checkStep("ow.wrap", 0, 15'h0FE3, 1'b0);
        step(); step(); step();
        checkStep("ow.new", 3, 15'h1AE3, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/microcode_sequencer.md
Name: microcode_sequencer

Overview:
- Parametrised, writable-microcode successor to the fixed control decoder.
- Steps through T-states and emits the control word for the CPU datapath (PC, MAR/RAM, IR, A, ALU, B, OUT).
- Adds over the fixed decoder:
  - runtime-loadable microcode;
  - variable-length instructions (early END);
  - flag-conditional steps on CF/ZF;
  - HALT state;
  - run/stall input.

Parameters:
- OPCODE_W, 4, opcode width; 2^OPCODE_W opcodes.
- CTRL_W, 15, control word width.
- NUM_T, 6, maximum T-states per instruction (t = 0..NUM_T-1).
- FETCH_T, 3, number of leading opcode-independent fetch steps (1 <= FETCH_T < NUM_T).
- IDLE_WORD, 15'h0FE3, safe control word with every active-low load/enable deasserted.
- Derived:
  - DEPTH = FETCH_T + 2^OPCODE_W*(NUM_T-FETCH_T), which is 51 at defaults.
  - AW = $clog2(DEPTH).
  - WORD_W = CTRL_W+4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- opcode  in  OPCODE_W  current instruction opcode from the IR.
- cf  in  1  ALU carry flag.
- zf  in  1  ALU zero flag.
- run  in  1  1 = advance one T-state per cycle; 0 = stall.
- uc_we  in  1  microcode write strobe.
- uc_addr  in  AW  microcode write address.
- uc_wdata  in  WORD_W  microcode word: [CTRL_W-1:0] ctrl, [CTRL_W] END, [CTRL_W+1] HLT, [CTRL_W+3:CTRL_W+2] COND.
- ctrl_out  out  CTRL_W  control word for the datapath.
- t_state  out  $clog2(NUM_T)  current T-state.
- halted  out  1  sequencer halted.
- instr_done  out  1  current cycle is the final step of an instruction.

Behaviour:
- Reset (rst=1 at an edge):
  - t_state=0, halted=0.
  - Every microcode row: ctrl=IDLE_WORD, END=0, HLT=0, COND=00.
  - Outputs after reset: ctrl_out=IDLE_WORD, instr_done=0 unless run=1 and t=NUM_T-1.
  - Reset mid-instruction or while halted behaves identically.
- Row select: row = t when t<FETCH_T, else FETCH_T + opcode*(NUM_T-FETCH_T) + (t-FETCH_T).
- COND condition pass:
  - 00: always.
  - 01: cf=1.
  - 10: zf=1.
  - 11: zf=0.
- ctrl_out is combinational from t_state, opcode, cf, zf, run and halted, valid in the same cycle:
  - halted=1, or run=0, or condition fails: ctrl_out=IDLE_WORD.
  - otherwise: ctrl_out = row.ctrl.
- Effective END (last step) = condition fails, or row.END=1, or t=NUM_T-1.
- instr_done = run & ~halted & ~(pass & HLT) & last.
- Next-state rules at each edge, with rst=0:
  - halted=1: hold everything; only rst clears it.
  - run=0: t holds.
  - run=1, pass & HLT: halted<=1, t holds. HLT takes priority over END.
  - run=1, last: t<=0.
  - otherwise: t<=t+1.
- Microcode write:
  - uc_we=1 and uc_addr<DEPTH: row written at the edge; visible on ctrl_out from the next cycle.
  - uc_addr>=DEPTH: write ignored.
  - Writes are accepted in any state, including halted and run=0.
  - rst takes priority over a same-cycle write.
- A fetch-region row with END or COND set applies as written; no special-casing.
- Storage is flops; DEPTH*WORD_W bits. No read port.

Test Plan:
- Reset, run=1, no writes (defaults) -> ctrl_out=15'h0FE3 every cycle; t_state cycles 0..5; instr_done=1 only when t_state=5, once every 6 cycles.
- Write rows 0,1,2 ctrl=15'h2FE3,15'h7DE3,15'h0F63; row 6 (opcode 1, t=3) ctrl=15'h0EE3 with END=1; opcode=1, run=1 -> ctrl_out 2FE3,7DE3,0F63,0EE3; instr_done at t=3; next cycle t_state=0.
- Row 24 (opcode 7, t=3) ctrl=15'h1FE3, COND=01; opcode=7:
  - cf=1 -> ctrl_out=1FE3 at t=3, then t=4.
  - cf=0 -> ctrl_out=0FE3 at t=3, instr_done=1, then t=0.
  - Repeat with COND=11: zf=0 passes, zf=1 fails.
- Row 48 (opcode 15, t=3) HLT=1; opcode=15 -> at t=3 instr_done=0; next cycle halted=1, t_state frozen at 3, ctrl_out=0FE3 for 20 cycles; rst pulse -> t_state=0, halted=0, all rows back to IDLE.
- run dropped at t=2 for 4 cycles -> t_state stays 2 and ctrl_out=0FE3; run=1 -> row-2 word appears that cycle, then t=3.
- Write uc_addr=60 -> no row changes. While t=3 with opcode=1, overwrite row 6 -> ctrl_out at t=3 shows the old word that cycle; the new word appears on the next pass through t=3.
